// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// A start/busy/done handshake lets it sit beside the array multiplier.
module seq_restoring_divider #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   t;
    logic             ge;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    // The trial value is one bit wider so divisors with the MSB set cannot overflow it.
    always_comb begin
        t      = {r_reg, q_reg[WIDTH-1]};
        ge     = (t >= {1'b0, d_reg});
        r_next = ge ? WIDTH'(t - {1'b0, d_reg}) : t[WIDTH-1:0];
        q_next = {q_reg[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        q_reg       <= dividend;
                        d_reg       <= divisor;
                        r_reg       <= '0;
                        cnt         <= CW'(WIDTH - 1);
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    cnt   <= cnt - CW'(1);
                    if (cnt == '0) begin
                        quotient  <= q_next;
                        remainder <= r_next;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and exhaustive checks of seq_restoring_divider with a result scoreboard.
module tb_seq_restoring_divider;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   done_cnt = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; drives start immediately so runs are back-to-back.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   lat;
        e.a   = a;
        e.b   = b;
        e.dbz = (b == 0);
        e.q   = (b == 0) ? {W{1'b1}} : W'(a / b);
        e.r   = (b == 0) ? a : W'(a % b);
        e.lat = (b == 0) ? 0 : W;
        sb.push_back(e);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk($sformatf("latency %0d/%0d", e.a, e.b), lat, e.lat);
        chk($sformatf("quotient %0d/%0d", e.a, e.b), quotient, e.q);
        chk($sformatf("remainder %0d/%0d", e.a, e.b), remainder, e.r);
        chk($sformatf("div_by_zero %0d/%0d", e.a, e.b), div_by_zero, e.dbz);
        chk($sformatf("busy_at_done %0d/%0d", e.a, e.b), busy, 1);
        if (e.b != 0) begin
            chk($sformatf("rem_lt_div %0d/%0d", e.a, e.b), remainder < e.b, 1);
            chk($sformatf("roundtrip %0d/%0d", e.a, e.b),
                quotient * e.b + remainder, e.a);
        end
        @(negedge clk);
        chk($sformatf("done_pulse %0d/%0d", e.a, e.b), done, 0);
        chk($sformatf("busy_after %0d/%0d", e.a, e.b), busy, 0);
    endtask

    initial begin
        int base;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_dbz", div_by_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        run_div(3'd7, 3'd2);
        run_div(3'd6, 3'd3);
        run_div(3'd2, 3'd7);
        run_div(3'd7, 3'd1);
        run_div(3'd0, 3'd5);
        run_div(3'd5, 3'd0);
        run_div(3'd6, 3'd3);

        // start pulses during CALC and DONE must be ignored
        base     = done_cnt;
        dividend = 3'd7;
        divisor  = 3'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        dividend = 3'd4;
        divisor  = 3'd4;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("busy_req_done", done, 1);
        chk("busy_req_quotient", quotient, 3);
        chk("busy_req_remainder", remainder, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_req_idle", busy, 0);
        repeat (6) @(negedge clk);
        chk("busy_req_still_idle", busy, 0);
        chk("busy_req_one_done", done_cnt - base, 1);
        chk("busy_req_hold_q", quotient, 3);

        // reset during CALC aborts without a done pulse
        base     = done_cnt;
        dividend = 3'd7;
        divisor  = 3'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        repeat (6) @(negedge clk);
        chk("abort_no_done", done_cnt - base, 0);
        run_div(3'd7, 3'd3);

        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                run_div(W'(a), W'(b));
            end
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
